// File: rtl/sram_sdram_bridge_if.sv
// Bus bundle between the core's SRAM-style port, the ROM-download port and the SDRAM controller.
// The bridge uses the master view; the core/controller side uses the slave view.
interface sram_sdram_bridge_if #(
  parameter int AW = 23
);
  logic          cpu_ce_n;
  logic          cpu_oe_n;
  logic          cpu_we_n;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_d;
  logic [7:0]    cpu_q;
  logic          cpu_rdy;

  logic          ioctl_download;
  logic          ioctl_wr;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          fifo_full;

  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic          mem_rd;
  logic          mem_we;
  logic [7:0]    mem_dout;
  logic          mem_ready;
  logic          err_timeout;

  modport master (
    input  cpu_ce_n, cpu_oe_n, cpu_we_n, cpu_addr, cpu_d,
    output cpu_q, cpu_rdy,
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    output fifo_full,
    output mem_addr, mem_din, mem_rd, mem_we,
    input  mem_dout, mem_ready,
    output err_timeout
  );

  modport slave (
    output cpu_ce_n, cpu_oe_n, cpu_we_n, cpu_addr, cpu_d,
    input  cpu_q, cpu_rdy,
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    input  fifo_full,
    input  mem_addr, mem_din, mem_rd, mem_we,
    output mem_dout, mem_ready,
    input  err_timeout
  );
endinterface

// File: rtl/sram_sdram_bridge.sv
// Converts level-based CPU strobes and queued ROM-download writes into single-cycle
// SDRAM rd/we commands; downloads win over the CPU, and stalled commands are aborted.
module sram_sdram_bridge #(
  parameter int AW         = 23,
  parameter int FIFO_DEPTH = 4,
  parameter int WAIT_MAX   = 255
) (
  input logic clk_sys,
  input logic reset_n,
  sram_sdram_bridge_if.master bus
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int TW = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {IDLE, WAIT_LO, WAIT_HI, DONE} state_t;

  state_t        state_q, state_d;
  logic          src_cpu_q, src_cpu_d;
  logic          is_read_q, is_read_d;
  logic          timed_out_q, timed_out_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;

  logic          prev_ce_n_q, prev_oe_n_q, prev_we_n_q;
  logic [AW-1:0] prev_addr_q;
  logic          pend_q, pend_d;
  logic          pend_wr_q, pend_wr_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic [7:0]    pend_data_q, pend_data_d;

  logic [AW+7:0] fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [7:0]    cpu_q_q, cpu_q_d;
  logic          cpu_rdy_q, cpu_rdy_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]    mem_din_q, mem_din_d;
  logic          mem_rd_q, mem_rd_d;
  logic          mem_we_q, mem_we_d;
  logic          err_timeout_q, err_timeout_d;

  logic detect, ce_rise, cpu_busy, fifo_full, fifo_empty, push, pop, accept;

  assign detect = !bus.cpu_ce_n &&
                  ((prev_oe_n_q && !bus.cpu_oe_n) ||
                   (prev_we_n_q && !bus.cpu_we_n) ||
                   (!bus.cpu_oe_n && (bus.cpu_addr != prev_addr_q)));
  assign ce_rise    = bus.cpu_ce_n && !prev_ce_n_q;
  assign cpu_busy   = (state_q != IDLE) && src_cpu_q;
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = bus.ioctl_wr && !fifo_full;

  always_comb begin
    state_d       = state_q;
    src_cpu_d     = src_cpu_q;
    is_read_d     = is_read_q;
    timed_out_d   = timed_out_q;
    wait_cnt_d    = wait_cnt_q;
    pend_d        = pend_q;
    pend_wr_d     = pend_wr_q;
    pend_addr_d   = pend_addr_q;
    pend_data_d   = pend_data_q;
    cpu_q_d       = cpu_q_q;
    cpu_rdy_d     = cpu_rdy_q;
    mem_addr_d    = mem_addr_q;
    mem_din_d     = mem_din_q;
    mem_rd_d      = 1'b0;
    mem_we_d      = 1'b0;
    err_timeout_d = err_timeout_q;
    pop           = 1'b0;
    accept        = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty && bus.mem_ready) begin
          pop                     = 1'b1;
          {mem_addr_d, mem_din_d} = fifo_mem_q[rd_ptr_q];
          mem_we_d                = 1'b1;
          src_cpu_d               = 1'b0;
          is_read_d               = 1'b0;
          timed_out_d             = 1'b0;
          wait_cnt_d              = '0;
          state_d                 = WAIT_LO;
        end else if (pend_q && !bus.ioctl_download && fifo_empty && bus.mem_ready) begin
          accept      = 1'b1;
          mem_addr_d  = pend_addr_q;
          mem_din_d   = pend_data_q;
          mem_we_d    = pend_wr_q;
          mem_rd_d    = !pend_wr_q;
          src_cpu_d   = 1'b1;
          is_read_d   = !pend_wr_q;
          timed_out_d = 1'b0;
          wait_cnt_d  = '0;
          state_d     = WAIT_LO;
        end
      end
      WAIT_LO, WAIT_HI: begin
        if (wait_cnt_q == TW'(WAIT_MAX)) begin
          err_timeout_d = 1'b1;
          timed_out_d   = 1'b1;
          state_d       = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (state_q == WAIT_LO && !bus.mem_ready) state_d = WAIT_HI;
          if (state_q == WAIT_HI && bus.mem_ready)  state_d = DONE;
        end
      end
      DONE: begin
        if (src_cpu_q) begin
          if (is_read_q && !timed_out_q) cpu_q_d = bus.mem_dout;
          cpu_rdy_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A fresh strobe edge overrides both acceptance and an abandoned request.
    if (accept) begin
      pend_d = 1'b0;
    end else if (ce_rise && pend_q) begin
      pend_d = 1'b0;
      if (!cpu_busy) cpu_rdy_d = 1'b1;
    end
    if (detect) begin
      pend_d      = 1'b1;
      pend_wr_d   = !bus.cpu_we_n;
      pend_addr_d = bus.cpu_addr;
      pend_data_d = bus.cpu_d;
      cpu_rdy_d   = 1'b0;
    end
  end

  assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  assign count_d  = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      src_cpu_q     <= 1'b0;
      is_read_q     <= 1'b0;
      timed_out_q   <= 1'b0;
      wait_cnt_q    <= '0;
      prev_ce_n_q   <= 1'b1;
      prev_oe_n_q   <= 1'b1;
      prev_we_n_q   <= 1'b1;
      prev_addr_q   <= '0;
      pend_q        <= 1'b0;
      pend_wr_q     <= 1'b0;
      pend_addr_q   <= '0;
      pend_data_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      cpu_q_q       <= '0;
      cpu_rdy_q     <= 1'b1;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
      mem_rd_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_cpu_q     <= src_cpu_d;
      is_read_q     <= is_read_d;
      timed_out_q   <= timed_out_d;
      wait_cnt_q    <= wait_cnt_d;
      prev_ce_n_q   <= bus.cpu_ce_n;
      prev_oe_n_q   <= bus.cpu_oe_n;
      prev_we_n_q   <= bus.cpu_we_n;
      prev_addr_q   <= bus.cpu_addr;
      pend_q        <= pend_d;
      pend_wr_q     <= pend_wr_d;
      pend_addr_q   <= pend_addr_d;
      pend_data_q   <= pend_data_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      cpu_q_q       <= cpu_q_d;
      cpu_rdy_q     <= cpu_rdy_d;
      mem_addr_q    <= mem_addr_d;
      mem_din_q     <= mem_din_d;
      mem_rd_q      <= mem_rd_d;
      mem_we_q      <= mem_we_d;
      err_timeout_q <= err_timeout_d;
      if (push) fifo_mem_q[wr_ptr_q] <= {bus.ioctl_addr, bus.ioctl_dout};
    end
  end

  assign bus.cpu_q       = cpu_q_q;
  assign bus.cpu_rdy     = cpu_rdy_q;
  assign bus.fifo_full   = fifo_full;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_din     = mem_din_q;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_sram_sdram_bridge.sv
// Scoreboard bench for sram_sdram_bridge: directed CPU/download traffic against a small
// SDRAM controller model, with expected commands and read results queued up front.
module tb_sram_sdram_bridge;

  localparam int AW         = 23;
  localparam int FIFO_DEPTH = 4;
  localparam int WAIT_MAX   = 255;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;

  always #20 clk_sys = ~clk_sys;

  sram_sdram_bridge_if #(.AW(AW)) bus ();

  sram_sdram_bridge #(.AW(AW), .FIFO_DEPTH(FIFO_DEPTH), .WAIT_MAX(WAIT_MAX)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    bit            is_write;
    logic [AW-1:0] addr;
    logic [7:0]    din;
    bit            rdy;
  } cmd_t;

  cmd_t       cmd_q[$];
  logic [7:0] resp_q[$];
  int         tests_run    = 0;
  int         tests_failed = 0;
  bit         model_hold   = 1'b0;
  bit         model_stuck  = 1'b0;
  int         busy_cnt     = 0;
  logic [7:0] tb_mem [logic [AW-1:0]];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] modelRead(input logic [AW-1:0] a);
    return tb_mem.exists(a) ? tb_mem[a] : 8'hEE;
  endfunction

  // SDRAM controller model: ready drops after a command and returns three cycles later,
  // unless held low (hold) or left low once it has dropped (stuck).
  always @(posedge clk_sys) begin
    if (!reset_n) begin
      bus.mem_ready <= 1'b1;
      bus.mem_dout  <= 8'h00;
      busy_cnt      <= 0;
    end else if (bus.mem_rd || bus.mem_we) begin
      bus.mem_ready <= 1'b0;
      busy_cnt      <= 3;
      bus.mem_dout  <= bus.mem_rd ? modelRead(bus.mem_addr) : 8'hEE;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy_cnt <= 0;
      if (!(model_stuck && !bus.mem_ready)) bus.mem_ready <= !model_hold;
    end
  end

  // Monitor: every command pulse and every cpu_rdy rise is checked against the queues.
  bit   prev_rdy = 1'b1;
  cmd_t exp_cmd;
  logic [7:0] exp_q;
  always @(negedge clk_sys) begin
    if (bus.mem_rd || bus.mem_we) begin
      if (cmd_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL cmd_unexpected: got rd=%0b we=%0b addr=0x%0h, expected no command",
                 bus.mem_rd, bus.mem_we, bus.mem_addr);
      end else begin
        exp_cmd = cmd_q.pop_front();
        checkOutput("cmd_kind", 32'({bus.mem_rd, bus.mem_we}), exp_cmd.is_write ? 32'd1 : 32'd2);
        checkOutput("cmd_addr", 32'(bus.mem_addr), 32'(exp_cmd.addr));
        if (exp_cmd.is_write) checkOutput("cmd_din", 32'(bus.mem_din), 32'(exp_cmd.din));
        checkOutput("cmd_cpu_rdy", 32'(bus.cpu_rdy), 32'(exp_cmd.rdy));
      end
    end
    if (!reset_n) begin
      prev_rdy = 1'b1;
    end else begin
      if (bus.cpu_rdy && !prev_rdy) begin
        if (resp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL rdy_unexpected: got cpu_rdy rise with cpu_q=0x%0h, expected none", bus.cpu_q);
        end else begin
          exp_q = resp_q.pop_front();
          checkOutput("cpu_q", 32'(bus.cpu_q), 32'(exp_q));
        end
      end
      prev_rdy = bus.cpu_rdy;
    end
  end

  task automatic applyStimulus(input logic ce_n, input logic oe_n, input logic we_n,
                               input logic [AW-1:0] addr, input logic [7:0] d);
    @(negedge clk_sys);
    bus.cpu_ce_n = ce_n;
    bus.cpu_oe_n = oe_n;
    bus.cpu_we_n = we_n;
    bus.cpu_addr = addr;
    bus.cpu_d    = d;
  endtask

  task automatic expectCmd(input bit is_write, input logic [AW-1:0] addr, input logic [7:0] din, input bit rdy);
    cmd_t c;
    c.is_write = is_write;
    c.addr     = addr;
    c.din      = din;
    c.rdy      = rdy;
    cmd_q.push_back(c);
  endtask

  task automatic waitRdy(input string name);
    int n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (!bus.cpu_rdy && n < 400);
    checkOutput(name, 32'(bus.cpu_rdy), 32'd1);
  endtask

  task automatic waitCmdsDone(input string name);
    int n = 0;
    while (cmd_q.size() != 0 && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    checkOutput(name, cmd_q.size(), 0);
    repeat (4) @(negedge clk_sys);
  endtask

  task automatic waitPulse(input string name);
    int n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (!bus.mem_rd && n < 20);
    checkOutput(name, 32'(bus.mem_rd), 32'd1);
  endtask

  task automatic checkReset(input string p);
    checkOutput({p, "_cpu_q"},       32'(bus.cpu_q),       32'h00);
    checkOutput({p, "_cpu_rdy"},     32'(bus.cpu_rdy),     32'd1);
    checkOutput({p, "_mem_rd"},      32'(bus.mem_rd),      32'd0);
    checkOutput({p, "_mem_we"},      32'(bus.mem_we),      32'd0);
    checkOutput({p, "_mem_addr"},    32'(bus.mem_addr),    32'd0);
    checkOutput({p, "_mem_din"},     32'(bus.mem_din),     32'd0);
    checkOutput({p, "_fifo_full"},   32'(bus.fifo_full),   32'd0);
    checkOutput({p, "_err_timeout"}, 32'(bus.err_timeout), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tb_mem[23'h001234] = 8'hA5;
    tb_mem[23'h000200] = 8'hC3;
    tb_mem[23'h000010] = 8'h5A;
    tb_mem[23'h000011] = 8'h77;
    bus.cpu_ce_n       = 1'b1;
    bus.cpu_oe_n       = 1'b1;
    bus.cpu_we_n       = 1'b1;
    bus.cpu_addr       = '0;
    bus.cpu_d          = '0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;

    repeat (3) @(negedge clk_sys);
    checkReset("rst");
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);

    // 1: CPU read
    expectCmd(1'b0, 23'h001234, 8'h00, 1'b0);
    resp_q.push_back(8'hA5);
    applyStimulus(1'b0, 1'b0, 1'b1, 23'h001234, 8'h00);
    @(negedge clk_sys);
    checkOutput("t1_rdy_low", 32'(bus.cpu_rdy), 32'd0);
    waitRdy("t1_rdy_back");
    applyStimulus(1'b1, 1'b1, 1'b1, 23'h001234, 8'h00);
    repeat (4) @(negedge clk_sys);

    // 2: CPU write, cpu_q keeps the last read value
    expectCmd(1'b1, 23'h7FFFFF, 8'h3C, 1'b0);
    resp_q.push_back(8'hA5);
    applyStimulus(1'b0, 1'b1, 1'b0, 23'h7FFFFF, 8'h3C);
    waitRdy("t2_rdy_back");
    applyStimulus(1'b1, 1'b1, 1'b1, 23'h7FFFFF, 8'h3C);
    repeat (4) @(negedge clk_sys);

    // 3: download burst into a stalled controller; writes 5 and 6 are dropped
    model_hold = 1'b1;
    repeat (3) @(negedge clk_sys);
    for (int i = 0; i < FIFO_DEPTH; i++) expectCmd(1'b1, AW'(i), 8'(8'h80 + i), 1'b1);
    bus.ioctl_download = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_sys);
      if (i == 3) checkOutput("t3_full_before_4th", 32'(bus.fifo_full), 32'd0);
      if (i == 4) checkOutput("t3_full_after_4th", 32'(bus.fifo_full), 32'd1);
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = AW'(i);
      bus.ioctl_dout = 8'(8'h80 + i);
    end
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
    checkOutput("t3_full_held", 32'(bus.fifo_full), 32'd1);
    bus.ioctl_download = 1'b0;
    model_hold = 1'b0;
    waitCmdsDone("t3_drain");
    checkOutput("t3_full_cleared", 32'(bus.fifo_full), 32'd0);

    // 4: downloads take priority over a pending CPU read
    model_hold = 1'b1;
    repeat (3) @(negedge clk_sys);
    expectCmd(1'b1, 23'h000100, 8'h11, 1'b0);
    expectCmd(1'b1, 23'h000101, 8'h22, 1'b0);
    expectCmd(1'b0, 23'h000200, 8'h00, 1'b0);
    resp_q.push_back(8'hC3);
    bus.ioctl_download = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 23'h000100; bus.ioctl_dout = 8'h11;
    @(negedge clk_sys);
    bus.ioctl_addr = 23'h000101; bus.ioctl_dout = 8'h22;
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 23'h000200, 8'h00);
    repeat (3) @(negedge clk_sys);
    checkOutput("t4_rdy_pending", 32'(bus.cpu_rdy), 32'd0);
    bus.ioctl_download = 1'b0;
    model_hold = 1'b0;
    waitCmdsDone("t4_cmds");
    waitRdy("t4_rdy_back");
    applyStimulus(1'b1, 1'b1, 1'b1, 23'h000200, 8'h00);
    repeat (4) @(negedge clk_sys);

    // 5: address change while oe_n stays low issues a second read
    expectCmd(1'b0, 23'h000010, 8'h00, 1'b0);
    resp_q.push_back(8'h5A);
    applyStimulus(1'b0, 1'b0, 1'b1, 23'h000010, 8'h00);
    waitRdy("t5_rdy_first");
    expectCmd(1'b0, 23'h000011, 8'h00, 1'b0);
    resp_q.push_back(8'h77);
    applyStimulus(1'b0, 1'b0, 1'b1, 23'h000011, 8'h00);
    waitRdy("t5_rdy_second");

    // 6: stuck controller times out without touching cpu_q, then reset mid-WAIT_HI
    model_stuck = 1'b1;
    expectCmd(1'b0, 23'h000020, 8'h00, 1'b0);
    resp_q.push_back(8'h77);
    applyStimulus(1'b0, 1'b0, 1'b1, 23'h000020, 8'h00);
    waitPulse("t6_pulse_first");
    repeat (WAIT_MAX) @(negedge clk_sys);
    checkOutput("t6_err_not_yet", 32'(bus.err_timeout), 32'd0);
    @(negedge clk_sys);
    checkOutput("t6_err_set", 32'(bus.err_timeout), 32'd1);
    waitRdy("t6_rdy_after_timeout");
    model_stuck = 1'b0;
    repeat (3) @(negedge clk_sys);
    model_stuck = 1'b1;
    expectCmd(1'b0, 23'h000021, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 23'h000021, 8'h00);
    waitPulse("t6_pulse_second");
    repeat (3) @(negedge clk_sys);
    checkOutput("t6_err_sticky", 32'(bus.err_timeout), 32'd1);
    checkOutput("t6_rdy_busy", 32'(bus.cpu_rdy), 32'd0);
    reset_n      = 1'b0;
    bus.cpu_ce_n = 1'b1;
    bus.cpu_oe_n = 1'b1;
    @(negedge clk_sys);
    checkReset("t6");
    reset_n     = 1'b1;
    model_stuck = 1'b0;
    repeat (10) @(negedge clk_sys);
    checkOutput("end_cmd_queue", cmd_q.size(), 0);
    checkOutput("end_resp_queue", resp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
